// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: load-use stall, taken-branch flush, data-memory freeze,
// registered EX operand forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter logic [2:0]  LOAD_SEL = 3'd1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       id_reg1,
  input  logic [4:0]       id_reg2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic             ex_have_inst,
  input  logic             ex_rf_we,
  input  logic [4:0]       ex_wr,
  input  logic [2:0]       ex_wd_sel,
  input  logic             ex_br_taken,
  input  logic             mem_rf_we,
  input  logic [4:0]       mem_wr,
  input  logic             dram_wait,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, LD_STALL, BR_FLUSH, MEM_WAIT} state_t;

  state_t           r_state;
  state_t           w_next;
  state_t           w_prio_next;
  logic             w_lu;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_cnt;

  // Youngest producer wins: EX result over MEM result; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (ex_rf_we && ex_wr != 5'd0 && ex_wr == rs)        return 2'd1;
    else if (mem_rf_we && mem_wr != 5'd0 && mem_wr == rs) return 2'd2;
    else                                                  return 2'd0;
  endfunction

  assign w_lu = ex_have_inst && ex_rf_we && (ex_wd_sel == LOAD_SEL) && (ex_wr != 5'd0) &&
                ((id_re1 && ex_wr == id_reg1) || (id_re2 && ex_wr == id_reg2));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= RUN;
    else          r_state <= w_next;
  end

  // Every state re-evaluates the same priority; the one-cycle states just fall back to RUN.
  always_comb begin
    w_prio_next = RUN;
    if (dram_wait)        w_prio_next = MEM_WAIT;
    else if (ex_br_taken) w_prio_next = BR_FLUSH;
    else if (w_lu)        w_prio_next = LD_STALL;
  end

  always_comb begin
    w_next = RUN;
    case (r_state)
      RUN, LD_STALL, BR_FLUSH, MEM_WAIT: w_next = w_prio_next;
      default:                           w_next = RUN;
    endcase
  end

  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    idex_flush = 1'b0;
    if (rst_n_i) begin
      if (dram_wait) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_stall = 1'b1;
      end else if (ex_br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_lu) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_fwd_a <= 2'd0;
      r_fwd_b <= 2'd0;
      r_cnt   <= '0;
    end else begin
      if (!idex_stall) begin
        if (idex_flush) begin
          r_fwd_a <= 2'd0;
          r_fwd_b <= 2'd0;
        end else begin
          r_fwd_a <= fwd_sel(id_reg1);
          r_fwd_b <= fwd_sel(id_reg2);
        end
      end
      if (pc_stall && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;
  assign stall_cnt = r_cnt;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the ID/EX stage boundary of the 5-stage core.
- Decides each cycle whether the PC, IF/ID and ID/EX registers advance, hold or take a bubble.
- Handles three cases: load-use hazards, taken branches/jumps resolved in EX, and data-memory wait.
- Produces registered forwarding selects consumed by the EX-stage operand muxes, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- LOAD_SEL, 3'd1: ex_wd_sel encoding that marks a load (write-back data from DRAM).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset. One clock; reset is synchronous and active-low.
- id_reg1  in  5  rs1 index of the instruction in ID.
- id_reg2  in  5  rs2 index of the instruction in ID.
- id_re1  in  1  ID instruction reads rs1.
- id_re2  in  1  ID instruction reads rs2.
- ex_have_inst  in  1  EX holds a valid instruction.
- ex_rf_we  in  1  EX instruction writes the RF.
- ex_wr  in  5  EX destination register.
- ex_wd_sel  in  3  EX write-back source select.
- ex_br_taken  in  1  branch/jump resolved taken in EX this cycle.
- mem_rf_we  in  1  MEM instruction writes the RF.
- mem_wr  in  5  MEM destination register.
- dram_wait  in  1  data memory not ready; whole pipe must freeze.
- pc_stall  out  1  PC holds.
- ifid_stall  out  1  IF/ID holds.
- ifid_flush  out  1  IF/ID loads a bubble.
- idex_stall  out  1  ID/EX holds.
- idex_flush  out  1  ID/EX loads a bubble (have_inst=0, all write enables 0).
- fwd_a_sel  out  2  EX operand A source: 0 RF, 1 MEM-stage ALU result, 2 WB data.
- fwd_b_sel  out  2  EX operand B source, same encoding.
- stall_cnt  out  CNT_W  count of cycles with pc_stall=1, saturating.

Behaviour:
- FSM states: RUN, LD_STALL, BR_FLUSH, MEM_WAIT. Reset state is RUN.
- Control outputs (pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush) are combinational (Mealy) from state and inputs; they act in the same cycle.
- fwd_a_sel, fwd_b_sel and stall_cnt are registered.
- While rst_n_i=0 all control outputs are forced to 0. On the first clock edge with rst_n_i=0: state←RUN, fwd_*_sel←0, stall_cnt←0. This applies from any state, including mid-MEM_WAIT.
- Hazard terms:
  - lu = ex_have_inst & ex_rf_we & ex_wd_sel==LOAD_SEL & ex_wr!=0 & ((id_re1 & ex_wr==id_reg1) | (id_re2 & ex_wr==id_reg2)).
- Priority each cycle: dram_wait > ex_br_taken > lu > none.
- dram_wait=1: pc_stall=ifid_stall=idex_stall=1, no flushes; next state MEM_WAIT. The state persists while dram_wait=1 and returns to RUN the cycle after it drops. A branch pending in EX is held and acted on after the wait.
- ex_br_taken=1 (no wait): ifid_flush=idex_flush=1, pc_stall=0 so the PC takes the target; next state BR_FLUSH. Any simultaneous lu is ignored because the ID instruction is squashed.
- BR_FLUSH lasts exactly 1 cycle and then goes to RUN. Outputs follow the normal priority; the inputs are bubbles, so normally nothing is asserted.
- lu=1 (no wait, no branch): pc_stall=ifid_stall=1, idex_flush=1; next state LD_STALL. LD_STALL lasts 1 cycle and then goes to RUN. The load has moved on, so lu is normally 0 there; if lu is asserted again it is re-evaluated normally.
- Forwarding update, on each edge where the ID/EX register advances (idex_stall=0):
  - If idex_flush=1: both selects←0.
  - Else for operand A: sel←1 if ex_rf_we & ex_wr!=0 & ex_wr==id_reg1; else sel←2 if mem_rf_we & mem_wr!=0 & mem_wr==id_reg1; else 0. Operand B uses the same rule with id_reg2.
  - The EX match takes priority over the MEM match (youngest producer wins).
  - When idex_stall=1, the selects hold.
- stall_cnt increments on each edge where pc_stall=1. It saturates at all-ones and never wraps.

Test Plan:
- Reset mid-MEM_WAIT: dram_wait=1 for 3 cycles, rst_n_i=0 on cycle 2 → controls 0 during reset; after reset state RUN, fwd sels 0, stall_cnt=0.
- Load-use: EX is a load to x5, ID reads rs1=x5 → one cycle with pc_stall=ifid_stall=idex_flush=1; next cycle no stall; when the ID instruction enters EX, fwd_a_sel=2; stall_cnt increments by 1.
- ALU back-to-back: EX is an ALU op writing x7, ID reads rs2=x7 → no stall; next cycle fwd_b_sel=1. With the same register also matching MEM, the select is still 1.
- Write to x0: EX is a load to x0, ID reads x0 → no stall, fwd_a_sel=0.
- Branch + load-use at once: ex_br_taken=1 and lu=1 → ifid_flush=idex_flush=1, pc_stall=0; next cycle fwd sels 0; stall_cnt unchanged.
- Wait + branch, then saturation: dram_wait=1 for 4 cycles with ex_br_taken=1 → 4 cycles of full freeze, then flush on cycle 5. Separately, preload stall_cnt near max with CNT_W=4 → count reaches 15 and holds.
